// File: rtl/ctrl_pkg.sv
// Shared opcode classes, function codes, FSM states and the control bundle
// for the pipelined decode controller.
package ctrl_pkg;

  localparam logic [1:0] REGISTER_TYPE  = 2'b00;
  localparam logic [1:0] IMMEDIATE_TYPE = 2'b01;
  localparam logic [2:0] MEMORY_TYPE    = 3'b100;
  localparam logic [2:0] SHIFT_TYPE     = 3'b110;

  localparam logic [1:0] STM_FN = 2'b00;
  localparam logic [1:0] LDM_FN = 2'b01;
  localparam logic [3:0] ADD_FN = 4'b0000;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       src_reg2;
    logic       src_const;
    logic       src_shift;
    logic       cin;
    logic       wr_src_alu;
    logic       wr_src_mem;
    logic       rd_reg2_src;
    logic       wen;
    logic       mem_read;
    logic       mem_write;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: opcode -> control bundle plus illegal flag.
// Illegal opcodes yield an all-zero bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output ctrl_bundle_t bundle,
  output logic         illegal
);

  // Opcode class and function decode.
  always_comb begin
    bundle  = '0;
    illegal = 1'b0;
    if (opcode[5:4] == REGISTER_TYPE) begin
      bundle.alu_op     = {1'b0, opcode[3:1]};
      bundle.src_reg2   = 1'b1;
      bundle.cin        = 1'b1;
      bundle.wr_src_alu = 1'b1;
      bundle.wen        = 1'b1;
    end else if (opcode[5:4] == IMMEDIATE_TYPE) begin
      bundle.alu_op     = {1'b0, opcode[3:1]};
      bundle.src_const  = 1'b1;
      bundle.cin        = 1'b1;
      bundle.wr_src_alu = 1'b1;
      bundle.wen        = 1'b1;
    end else if (opcode[5:3] == SHIFT_TYPE) begin
      bundle.alu_op     = {2'b11, opcode[2:1]};
      bundle.src_shift  = 1'b1;
      bundle.cin        = 1'b1;
      bundle.wr_src_alu = 1'b1;
      bundle.wen        = 1'b1;
    end else if (opcode[5:3] == MEMORY_TYPE) begin
      // Address always comes from reg1 + immediate; unknown memory fns stay all-zero.
      case (opcode[2:1])
        STM_FN: begin
          bundle.alu_op      = ADD_FN;
          bundle.src_const   = 1'b1;
          bundle.mem_write   = 1'b1;
          bundle.rd_reg2_src = 1'b1;
        end
        LDM_FN: begin
          bundle.alu_op     = ADD_FN;
          bundle.src_const  = 1'b1;
          bundle.mem_read   = 1'b1;
          bundle.wr_src_mem = 1'b1;
          bundle.wen        = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// Decode->execute stage register with a handshaked front end and a small FSM
// that holds memory ops until mem_ready, with a sticky timeout indication.
module pipelined_controller
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic               mem_ready,
  output logic               ctrl_valid,
  output logic [3:0]         ALU_op,
  output logic               sel_ALU_src_reg2,
  output logic               sel_ALU_src_const,
  output logic               sel_ALU_src_shift_count,
  output logic               sel_Cin_alu,
  output logic               sel_RF_write_src_ALU,
  output logic               sel_RF_write_src_MEM,
  output logic               sel_RF_read_reg2_src,
  output logic               RF_write_en,
  output logic               MEM_read,
  output logic               MEM_write,
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  ctrl_bundle_t stage, next_stage;
  ctrl_bundle_t dec_bundle;
  logic         dec_illegal;
  logic         next_valid, next_illegal, next_timeout;
  logic         accept;

  ctrl_decode u_decode (
    .opcode  (instruction[INSTR_W-1 -: 6]),
    .bundle  (dec_bundle),
    .illegal (dec_illegal)
  );

  generate
    if (INSTR_W > 6) begin : g_operand_bits
      logic unused_operand;
      assign unused_operand = ^instruction[INSTR_W-7:0];
    end
  endgenerate

  assign instr_ready = (state == RUN) & ~ex_stall & ~flush & ~rst;
  assign accept      = instr_valid & instr_ready;

  // Next-state, counter and stage-register update; earlier branches take priority.
  always_comb begin
    next_state   = RUN;
    next_cnt     = '0;
    next_stage   = '0;
    next_valid   = 1'b0;
    next_illegal = 1'b0;
    next_timeout = mem_timeout;
    if (flush) begin
      next_state = RUN;
    end else if (state == MEM_WAIT) begin
      if (mem_ready) begin
        next_state = RUN;
      end else if (cnt == CNT_MAX) begin
        next_timeout = 1'b1;
      end else begin
        next_state   = MEM_WAIT;
        next_cnt     = cnt + CNT_W'(1);
        next_stage   = stage;
        next_valid   = ctrl_valid;
        next_illegal = illegal_op;
      end
    end else if (ctrl_valid & ex_stall) begin
      next_stage   = stage;
      next_valid   = ctrl_valid;
      next_illegal = illegal_op;
    end else if (accept) begin
      next_stage   = dec_bundle;
      next_valid   = 1'b1;
      next_illegal = dec_illegal;
      if (dec_bundle.mem_read | dec_bundle.mem_write) begin
        next_state = MEM_WAIT;
      end else begin
        next_state = RUN;
      end
    end else begin
      next_state = RUN;
    end
  end

  // State, counter and stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      stage       <= '0;
      ctrl_valid  <= 1'b0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      stage       <= next_stage;
      ctrl_valid  <= next_valid;
      illegal_op  <= next_illegal;
      mem_timeout <= next_timeout;
    end
  end

  assign ALU_op                  = stage.alu_op;
  assign sel_ALU_src_reg2        = stage.src_reg2;
  assign sel_ALU_src_const       = stage.src_const;
  assign sel_ALU_src_shift_count = stage.src_shift;
  assign sel_Cin_alu             = stage.cin;
  assign sel_RF_write_src_ALU    = stage.wr_src_alu;
  assign sel_RF_write_src_MEM    = stage.wr_src_mem;
  assign sel_RF_read_reg2_src    = stage.rd_reg2_src;
  assign MEM_read                = stage.mem_read;
  assign MEM_write               = stage.mem_write;
  // A load only writes the register file in the cycle memory delivers data.
  assign RF_write_en = stage.wen & (~stage.mem_read | ((state == MEM_WAIT) & mem_ready));

endmodule
